output_write_arbiter: RTL and testbench

- Shares the single write port of the output-device register bank between two requesters: r0 is the CPU store path and r1 is the I/O/DMA sequencer.
- Each requester hands over one write through a valid/ready handshake into a private one-entry slot.
- A round-robin arbiter issues at most one write per cycle onto address/value/is_write, registered, for the output device bank to sample on the next rising clk.
- Writes to nonexistent device addresses are dropped and flagged.

---
 rtl/output_write_arbiter_pkg.sv | 16 +
 rtl/output_write_arbiter_if.sv | 50 +++++
 rtl/output_write_arbiter_write_slot.sv | 63 ++++++
 rtl/output_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_output_write_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/output_write_arbiter_pkg.sv
// Shared definitions for the output-device write path.
// Holds the default bus widths, the number of output devices present in the
// bank and the one-entry slot state encoding. The output device bank imports
// the same package so both sides agree on the address map.
package output_write_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF     = 8;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int NUM_OUTPUT_DEVICES = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/output_write_arbiter_if.sv
// Bundle of every handshake and device-bank signal of output_write_arbiter.
//   r0_*  : CPU store path requester (valid/ready/address/value, done pulse)
//   r1_*  : I/O-DMA sequencer requester (same shape as r0_*)
//   address/value/is_write : registered write towards the device bank
//   err_bad_address/err_clear : sticky dropped-write flag and its clear
//   busy  : any slot full or a write on the bus
// Modport slave is the arbiter side, master is the requester/bank side.
interface output_write_arbiter_if
  import output_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  r0_valid;
  logic                  r0_ready;
  logic [ADDR_WIDTH-1:0] r0_address;
  logic [DATA_WIDTH-1:0] r0_value;
  logic                  r0_done;

  logic                  r1_valid;
  logic                  r1_ready;
  logic [ADDR_WIDTH-1:0] r1_address;
  logic [DATA_WIDTH-1:0] r1_value;
  logic                  r1_done;

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] value;
  logic                  is_write;
  logic                  err_bad_address;
  logic                  err_clear;
  logic                  busy;

  modport slave (
    input  r0_valid, r0_address, r0_value,
    input  r1_valid, r1_address, r1_value,
    input  err_clear,
    output r0_ready, r0_done, r1_ready, r1_done,
    output address, value, is_write, err_bad_address, busy
  );

  modport master (
    output r0_valid, r0_address, r0_value,
    output r1_valid, r1_address, r1_value,
    output err_clear,
    input  r0_ready, r0_done, r1_ready, r1_done,
    input  address, value, is_write, err_bad_address, busy
  );

endinterface

// File: rtl/output_write_arbiter_write_slot.sv
// One-entry write buffer for a single requester.
//   clk, reset_n       : clock and asynchronous active-low reset
//   valid_i, ready_o   : requester handshake; ready_o is high while empty
//   addr_i, value_i    : write captured on the valid && ready edge
//   grant_i            : arbiter took the entry this edge, slot empties
//   full_o, addr_o, value_o : held entry presented to the arbiter
// There is no same-edge refill: a granted slot shows ready one cycle later.
module output_write_arbiter_write_slot
  import output_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  grant_i,
  output logic                  ready_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] value_o
);

  slot_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  capture;

  assign capture = valid_i && (state_q == SLOT_EMPTY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload carries no reset: it is only observed while the slot is FULL.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= addr_i;
      value_q <= value_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (valid_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (grant_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  assign ready_o = (state_q == SLOT_EMPTY);
  assign full_o  = (state_q == SLOT_FULL);
  assign addr_o  = addr_q;
  assign value_o = value_q;

endmodule

// File: rtl/output_write_arbiter.sv
// Shares the single write port of the output-device bank between the CPU
// store path (r0) and the I/O-DMA sequencer (r1).
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : output_write_arbiter_if.slave, carrying both requester
//                  handshakes, the registered address/value/is_write towards
//                  the device bank, err_bad_address/err_clear and busy
// Each requester owns a one-entry slot; a round-robin arbiter issues at most
// one registered write per cycle. Writes to address >= NUM_DEVICES are
// granted and acknowledged but dropped, setting the sticky error flag.
module output_write_arbiter
  import output_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_DEVICES = NUM_OUTPUT_DEVICES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output_write_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] NUM_DEV_A = ADDR_WIDTH'(NUM_DEVICES);

  logic                  full0, full1;
  logic [ADDR_WIDTH-1:0] s0_addr, s1_addr;
  logic [DATA_WIDTH-1:0] s0_value, s1_value;
  logic                  grant0, grant1;
  logic                  last_grant_q, last_grant_d;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_value;
  logic                  addr_ok;

  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  err_q, err_d;

  // Stage 0: requester handshakes land in private one-entry slots.
  output_write_arbiter_write_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot0 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (bus.r0_valid),
    .addr_i  (bus.r0_address),
    .value_i (bus.r0_value),
    .grant_i (grant0),
    .ready_o (bus.r0_ready),
    .full_o  (full0),
    .addr_o  (s0_addr),
    .value_o (s0_value)
  );

  output_write_arbiter_write_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slot1 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (bus.r1_valid),
    .addr_i  (bus.r1_address),
    .value_i (bus.r1_value),
    .grant_i (grant1),
    .ready_o (bus.r1_ready),
    .full_o  (full1),
    .addr_o  (s1_addr),
    .value_o (s1_value)
  );

  // Stage 1: arbitration on the current full flags. last_grant only moves on
  // a contested cycle; last_grant_q=1 means r0 wins the next tie.
  always_comb begin
    grant0       = 1'b0;
    grant1       = 1'b0;
    last_grant_d = last_grant_q;
    if (full0 && full1) begin
      if (last_grant_q) grant0 = 1'b1;
      else              grant1 = 1'b1;
      last_grant_d = ~last_grant_q;
    end else begin
      grant0 = full0;
      grant1 = full1;
    end
  end

  assign sel_addr  = grant1 ? s1_addr  : s0_addr;
  assign sel_value = grant1 ? s1_value : s0_value;
  assign addr_ok   = (sel_addr < NUM_DEV_A);

  always_comb begin
    is_write_d = 1'b0;
    address_d  = address_q;
    value_d    = value_q;
    done0_d    = grant0;
    done1_d    = grant1;
    err_d      = err_q;
    if (grant0 || grant1) begin
      address_d  = sel_addr;
      value_d    = sel_value;
      is_write_d = addr_ok;
    end
    if (bus.err_clear) err_d = 1'b0;
    // A new drop on the same edge as a clear keeps the flag set.
    if ((grant0 || grant1) && !addr_ok) err_d = 1'b1;
  end

  // Stage 2: issue registers seen by the device bank on the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      is_write_q   <= 1'b0;
      address_q    <= '0;
      value_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      address_q    <= address_d;
      value_q      <= value_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
    end
  end

  assign bus.is_write        = is_write_q;
  assign bus.address         = address_q;
  assign bus.value           = value_q;
  assign bus.r0_done         = done0_q;
  assign bus.r1_done         = done1_q;
  assign bus.err_bad_address = err_q;
  assign bus.busy            = full0 || full1 || is_write_q;

endmodule

// File: tb/tb_output_write_arbiter.sv
module tb_output_write_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  output_write_arbiter_if bus ();

  output_write_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Device bank: samples a write on the edge after is_write is presented.
  logic [31:0] dev [2] = '{32'h0, 32'h0};
  always @(posedge clk) begin
    if (bus.is_write && bus.address < 8'd2) dev[bus.address[0]] <= bus.value;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: pending write per requester, issue register, device copy.
  logic        m_full [2];
  logic [7:0]  m_sa   [2];
  logic [31:0] m_sd   [2];
  logic        m_last;
  logic        m_iw, m_done0, m_done1, m_err;
  logic [7:0]  m_addr;
  logic [31:0] m_val;
  logic [31:0] m_dev  [2] = '{32'h0, 32'h0};
  int          n_done [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_last    = 1'b1;
    m_iw      = 1'b0;
    m_done0   = 1'b0;
    m_done1   = 1'b0;
    m_err     = 1'b0;
    m_addr    = 8'h0;
    m_val     = 32'h0;
  endtask

  task automatic model_edge(input logic v0, input logic [7:0] a0, input logic [31:0] d0,
                            input logic v1, input logic [7:0] a1, input logic [31:0] d1,
                            input logic clr);
    int   g;
    logic cap0, cap1;
    if (m_iw) m_dev[m_addr[0]] = m_val;
    cap0 = v0 && !m_full[0];
    cap1 = v1 && !m_full[1];
    g = -1;
    if (m_full[0] && m_full[1]) begin
      g = m_last ? 0 : 1;
      m_last = (g == 1);
    end else if (m_full[0]) g = 0;
    else if (m_full[1]) g = 1;
    m_done0 = (g == 0);
    m_done1 = (g == 1);
    if (g >= 0) begin
      m_addr = m_sa[g];
      m_val  = m_sd[g];
      m_iw   = (m_sa[g] < 8'd2);
      m_full[g] = 1'b0;
      if (!m_iw) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end else begin
      m_iw = 1'b0;
      if (clr) m_err = 1'b0;
    end
    if (cap0) begin m_full[0] = 1'b1; m_sa[0] = a0; m_sd[0] = d0; end
    if (cap1) begin m_full[1] = 1'b1; m_sa[1] = a1; m_sd[1] = d1; end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".r0_ready"}, 32'(bus.r0_ready), 32'(!m_full[0]));
    check({ph, ".r1_ready"}, 32'(bus.r1_ready), 32'(!m_full[1]));
    check({ph, ".is_write"}, 32'(bus.is_write), 32'(m_iw));
    check({ph, ".address"},  32'(bus.address),  32'(m_addr));
    check({ph, ".value"},    bus.value,          m_val);
    check({ph, ".r0_done"},  32'(bus.r0_done),  32'(m_done0));
    check({ph, ".r1_done"},  32'(bus.r1_done),  32'(m_done1));
    check({ph, ".err"},      32'(bus.err_bad_address), 32'(m_err));
    check({ph, ".busy"},     32'(bus.busy), 32'(m_full[0] || m_full[1] || m_iw));
    check({ph, ".dev0"},     dev[0], m_dev[0]);
    check({ph, ".dev1"},     dev[1], m_dev[1]);
  endtask

  task automatic cycle(input string ph,
                       input logic v0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [7:0] a1, input logic [31:0] d1,
                       input logic clr);
    bus.r0_valid   = v0;
    bus.r0_address = a0;
    bus.r0_value   = d0;
    bus.r1_valid   = v1;
    bus.r1_address = a1;
    bus.r1_value   = d1;
    bus.err_clear  = clr;
    @(posedge clk);
    model_edge(v0, a0, d0, v1, a1, d1, clr);
    #1;
    check_all(ph);
    if (bus.r0_done) n_done[0]++;
    if (bus.r1_done) n_done[1]++;
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int          prev_g;
    int          guard;
    logic [31:0] snap0, snap1;
    logic [7:0]  held_addr;
    logic [31:0] held_val;

    bus.r0_valid = 1'b0; bus.r0_address = 8'h0; bus.r0_value = 32'h0;
    bus.r1_valid = 1'b0; bus.r1_address = 8'h0; bus.r1_value = 32'h0;
    bus.err_clear = 1'b0;
    n_done[0] = 0;
    n_done[1] = 0;
    model_reset();

    // Outputs must be defined by reset alone, before any clock edge.
    #1;
    check_all("reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write from r0.
    cycle("single", 1'b1, 8'd0, 32'hE5F84AB1, 1'b0, 8'd0, 32'h0, 1'b0);
    check("single.ready_low", 32'(bus.r0_ready), 32'd0);
    idle("single", 1);
    check("single.is_write_E1", 32'(bus.is_write), 32'd1);
    check("single.done_E1", 32'(bus.r0_done), 32'd1);
    idle("single", 1);
    check("single.is_write_off", 32'(bus.is_write), 32'd0);
    check("single.dev0", dev[0], 32'hE5F84AB1);

    // Tie on the first contested cycle after reset: r0 first, then r1.
    cycle("tie", 1'b1, 8'd0, 32'hE5F84AB1, 1'b1, 8'd1, 32'h5C8C6A01, 1'b0);
    idle("tie", 1);
    check("tie.first_r0", 32'(bus.r0_done), 32'd1);
    idle("tie", 1);
    check("tie.second_r1", 32'(bus.r1_done), 32'd1);
    check("tie.is_write_2nd", 32'(bus.is_write), 32'd1);
    idle("tie", 2);
    check("tie.dev0", dev[0], 32'hE5F84AB1);
    check("tie.dev1", dev[1], 32'h5C8C6A01);

    // Both requesters keep re-presenting: grants must alternate.
    n_done[0] = 0;
    n_done[1] = 0;
    prev_g = -1;
    guard  = 0;
    while ((n_done[0] < 8 || n_done[1] < 8) && guard < 60) begin
      cycle("fair", n_done[0] + (m_full[0] ? 1 : 0) < 8, 8'($urandom_range(0, 1)), $urandom,
                    n_done[1] + (m_full[1] ? 1 : 0) < 8, 8'($urandom_range(0, 1)), $urandom, 1'b0);
      if (bus.r0_done || bus.r1_done) begin
        if (prev_g >= 0) check("fair.alternate", 32'(bus.r1_done ? 1 : 0), 32'(prev_g == 0 ? 1 : 0));
        prev_g = bus.r1_done ? 1 : 0;
      end
      guard++;
    end
    check("fair.r0_count", 32'(n_done[0]), 32'd8);
    check("fair.r1_count", 32'(n_done[1]), 32'd8);
    idle("fair", 3);

    // Bad address: dropped, flagged, sticky, clearable; set beats clear.
    cycle("bad", 1'b0, 8'd0, 32'h0, 1'b1, 8'd5, 32'hDEADBEEF, 1'b0);
    idle("bad", 1);
    check("bad.done", 32'(bus.r1_done), 32'd1);
    check("bad.no_write", 32'(bus.is_write), 32'd0);
    check("bad.err_set", 32'(bus.err_bad_address), 32'd1);
    idle("bad", 3);
    check("bad.err_hold", 32'(bus.err_bad_address), 32'd1);
    cycle("bad", 1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 32'h0, 1'b1);
    check("bad.err_clear", 32'(bus.err_bad_address), 32'd0);
    cycle("bad", 1'b0, 8'd0, 32'h0, 1'b1, 8'd7, 32'h12345678, 1'b0);
    cycle("bad", 1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 32'h0, 1'b1);
    check("bad.set_wins", 32'(bus.err_bad_address), 32'd1);
    idle("bad", 2);

    // Randomized traffic including bad addresses and occasional clears.
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), $urandom,
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 7) == 0);
    end
    idle("rand", 3);

    // Reset between acceptance and grant discards the write.
    snap0 = dev[0];
    snap1 = dev[1];
    cycle("rst", 1'b1, 8'd1, ~snap1, 1'b0, 8'd0, 32'h0, 1'b0);
    bus.r0_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    idle("rst", 3);
    check("rst.dev0", dev[0], snap0);
    check("rst.dev1", dev[1], snap1);
    check("rst.r0_ready", 32'(bus.r0_ready), 32'd1);

    // Idle: address and value hold.
    cycle("pre_idle", 1'b1, 8'd0, 32'hA5A5F00D, 1'b0, 8'd0, 32'h0, 1'b0);
    idle("pre_idle", 2);
    held_addr = bus.address;
    held_val  = bus.value;
    idle("idle", 10);
    check("idle.is_write", 32'(bus.is_write), 32'd0);
    check("idle.busy", 32'(bus.busy), 32'd0);
    check("idle.address", 32'(bus.address), 32'(held_addr));
    check("idle.value", bus.value, held_val);
    check("idle.dev0", dev[0], 32'hA5A5F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
